la_ohdemux4: RTL and testbench



---
 rtl/la_ohdemux4.sv | 149 ++++++++++++++
 tb/tb_la_ohdemux4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/la_ohdemux4.sv
// la_ohdemux4: registered 4-way one-hot stream demultiplexer.
// One beat per cycle enters on a single valid/ready port with a one-hot
// select and leaves on the selected one of four valid/ready channels.
// A main register drives the outputs and a skid register absorbs the beat
// accepted in the cycle the output stalls, so in_ready can come straight
// from the state flops. Beats whose select is not one-hot are consumed,
// dropped, flagged on err and counted in a saturating err_count.

module la_ohdemux4 #(
   parameter int unsigned DW   = 8,
   parameter              PROP = "DEFAULT"
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_sel,
   input  logic [DW-1:0] in_data,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [DW-1:0] out_data,
   output logic          err,
   output logic [7:0]    err_count
);

   // PROP is a cell property passthrough with no functional effect.
   if (PROP == "") begin : g_prop_empty
   end

   typedef enum logic [1:0] {
      StEmpty,
      StBusy,
      StFull
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    main_sel_q, main_sel_d;
   logic [DW-1:0] main_data_q, main_data_d;
   logic [3:0]    skid_sel_q, skid_sel_d;
   logic [DW-1:0] skid_data_q, skid_data_d;
   logic          err_q, err_d;
   logic [7:0]    err_count_q, err_count_d;

   logic sel_onehot;
   logic accept;
   logic push;
   logic drop;
   logic pop;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign sel_onehot = (in_sel != 4'b0000) && ((in_sel & (in_sel - 4'd1)) == 4'b0000);

   // Ready depends only on the state flops; nothing combinational from the ports.
   assign in_ready = (state_q != StFull);

   assign accept = in_valid & in_ready;
   assign push   = accept & sel_onehot;
   assign drop   = accept & ~sel_onehot;

   // The main register holds the head beat in both BUSY and FULL.
   assign out_valid = (state_q == StEmpty) ? 4'b0000 : main_sel_q;
   assign out_data  = main_data_q;

   // Only the selected channel's ready can complete the transfer.
   assign pop = |(out_valid & out_ready);

   assign err       = err_q;
   assign err_count = err_count_q;

   // Next state and register loads for the main/skid pair.
   always_comb begin
      state_d     = state_q;
      main_sel_d  = main_sel_q;
      main_data_d = main_data_q;
      skid_sel_d  = skid_sel_q;
      skid_data_d = skid_data_q;
      case (state_q)
         StEmpty: begin
            if (push) begin
               state_d     = StBusy;
               main_sel_d  = in_sel;
               main_data_d = in_data;
            end
         end
         StBusy: begin
            if (push && pop) begin
               // Output advances to the new beat with no bubble.
               main_sel_d  = in_sel;
               main_data_d = in_data;
            end else if (push) begin
               state_d     = StFull;
               skid_sel_d  = in_sel;
               skid_data_d = in_data;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
               state_d     = StBusy;
               main_sel_d  = skid_sel_q;
               main_data_d = skid_data_q;
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
   end

   // Drop flag is a one-cycle pulse; the counter sticks at its maximum.
   always_comb begin
      err_d       = drop;
      err_count_d = err_count_q;
      if (drop && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   // State and error registers, cleared asynchronously.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= StEmpty;
         err_q       <= 1'b0;
         err_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
      end
   end

   // Beat storage; cleared on reset so outputs never show stale X.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         main_sel_q  <= 4'b0000;
         main_data_q <= '0;
         skid_sel_q  <= 4'b0000;
         skid_data_q <= '0;
      end else begin
         main_sel_q  <= main_sel_d;
         main_data_q <= main_data_d;
         skid_sel_q  <= skid_sel_d;
         skid_data_q <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_la_ohdemux4.sv
// Directed bench for la_ohdemux4: a table of per-cycle vectors plus
// hand-written sequences for counter saturation and reset while FULL.

module tb_la_ohdemux4;

   logic       clk;
   logic       nreset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_sel;
   logic [7:0] in_data;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] out_data;
   logic       err;
   logic [7:0] err_count;

   int total;
   int bad;

   la_ohdemux4 #(
      .DW   (8),
      .PROP ("DEFAULT")
   ) dut (
      .clk       (clk),
      .nreset    (nreset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .err       (err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs driven during a cycle, and the outputs expected in that same
   // cycle (before the rising edge that acts on the inputs).
   typedef struct {
      logic       v;
      logic [3:0] sel;
      logic [7:0] data;
      logic [3:0] rdy;
      logic [3:0] e_ov;
      logic [7:0] e_data;
      logic       e_ir;
      logic       e_err;
      logic [7:0] e_cnt;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [3:0] sel, input logic [7:0] data,
                               input logic [3:0] rdy, input logic [3:0] e_ov,
                               input logic [7:0] e_data, input logic e_ir, input logic e_err,
                               input logic [7:0] e_cnt, input string name);
      vec_t r;
      r.v = v; r.sel = sel; r.data = data; r.rdy = rdy;
      r.e_ov = e_ov; r.e_data = e_data; r.e_ir = e_ir; r.e_err = e_err; r.e_cnt = e_cnt;
      r.name = name;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      nreset    = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 4'b0000;
      in_data   = 8'h00;
      out_ready = 4'b0000;

      // Streaming: one-cycle latency, no bubbles, in_ready never drops.
      for (int i = 0; i < 8; i++) begin
         logic [3:0] s;
         logic [3:0] ps;
         s  = 4'b0001 << (i % 4);
         ps = (i == 0) ? 4'b0000 : (4'b0001 << ((i - 1) % 4));
         vecs.push_back(mk(1'b1, s, 8'h10 + 8'(i), 4'b1111, ps, 8'h10 + 8'(i) - 8'h01,
                           1'b1, 1'b0, 8'd0, "stream"));
      end
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b1111, 4'b1000, 8'h17, 1'b1, 1'b0, 8'd0, "stream_last"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "stream_idle"));
      // Back-pressure into FULL; the 0xFF beat must not be taken while in_ready is low.
      vecs.push_back(mk(1'b1, 4'b0100, 8'hA5, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "bp_push1"));
      vecs.push_back(mk(1'b1, 4'b0001, 8'h3C, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b0, 8'd0, "bp_push2"));
      vecs.push_back(mk(1'b1, 4'b0010, 8'hFF, 4'b0000, 4'b0100, 8'hA5, 1'b0, 1'b0, 8'd0, "bp_full"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0100, 4'b0100, 8'hA5, 1'b0, 1'b0, 8'd0, "bp_pop1"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0001, 8'h3C, 1'b1, 1'b0, 8'd0, "bp_skid"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0001, 4'b0001, 8'h3C, 1'b1, 1'b0, 8'd0, "bp_pop2"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "bp_empty"));
      // Readies of unselected channels are ignored.
      vecs.push_back(mk(1'b1, 4'b1000, 8'h5A, 4'b0111, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "unsel_push"));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0111, 4'b1000, 8'h5A, 1'b1, 1'b0, 8'd0, "unsel_hold"));
      end
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b1000, 4'b1000, 8'h5A, 1'b1, 1'b0, 8'd0, "unsel_pop"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "unsel_empty"));
      // Illegal selects: consumed, never forwarded, flagged and counted.
      vecs.push_back(mk(1'b1, 4'b0000, 8'h11, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd0, "ill_zero"));
      vecs.push_back(mk(1'b1, 4'b0110, 8'h22, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b1, 8'd1, "ill_multi"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b1, 8'd2, "ill_after"));
      vecs.push_back(mk(1'b0, 4'b0000, 8'h00, 4'b1111, 4'b0000, 8'h00, 1'b1, 1'b0, 8'd2, "ill_quiet"));

      // Reset values, checked while nreset is still asserted.
      #2;
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_err_count", 32'(err_count), 32'h0);

      // Release on a falling edge so the first vector's beat lands on the next rising edge.
      @(negedge clk);
      nreset = 1'b1;

      foreach (vecs[k]) begin
         if (k != 0) @(negedge clk);
         in_valid  = vecs[k].v;
         in_sel    = vecs[k].sel;
         in_data   = vecs[k].data;
         out_ready = vecs[k].rdy;
         #1;
         chk({vecs[k].name, "_out_valid"}, 32'(out_valid), 32'(vecs[k].e_ov));
         if (vecs[k].e_ov != 4'b0000) chk({vecs[k].name, "_out_data"}, 32'(out_data), 32'(vecs[k].e_data));
         chk({vecs[k].name, "_in_ready"}, 32'(in_ready), 32'(vecs[k].e_ir));
         chk({vecs[k].name, "_err"}, 32'(err), 32'(vecs[k].e_err));
         chk({vecs[k].name, "_err_count"}, 32'(err_count), 32'(vecs[k].e_cnt));
      end

      // Saturation: count starts at 2, climbs one per cycle, and sticks at 255.
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         in_sel    = (k % 2 == 0) ? 4'b0000 : 4'b1111;
         in_data   = 8'(k);
         out_ready = 4'b1111;
         #1;
         if (k == 252) chk("sat_254", 32'(err_count), 32'd254);
         if (k == 253) chk("sat_255", 32'(err_count), 32'd255);
         if (k == 299) chk("sat_out_valid", 32'(out_valid), 32'h0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("sat_hold", 32'(err_count), 32'd255);
      chk("sat_err_last", 32'(err), 32'h1);
      @(negedge clk);
      #1;
      chk("sat_err_clear", 32'(err), 32'h0);
      chk("sat_hold2", 32'(err_count), 32'd255);

      // Fill to FULL, then reset asynchronously mid-cycle.
      in_valid  = 1'b1;
      in_sel    = 4'b0001;
      in_data   = 8'hAA;
      out_ready = 4'b0000;
      @(negedge clk);
      in_sel  = 4'b0010;
      in_data = 8'hBB;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("rst_pre_in_ready", 32'(in_ready), 32'h0);
      chk("rst_pre_out_valid", 32'(out_valid), 32'h1);
      #1;
      nreset = 1'b0;
      #1;
      chk("rst_async_out_valid", 32'(out_valid), 32'h0);
      chk("rst_async_in_ready", 32'(in_ready), 32'h1);
      chk("rst_async_err_count", 32'(err_count), 32'h0);
      @(negedge clk);
      nreset   = 1'b1;
      in_valid = 1'b1;
      in_sel   = 4'b0100;
      in_data  = 8'hCC;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("rst_first_out_valid", 32'(out_valid), 32'h4);
      chk("rst_first_out_data", 32'(out_data), 32'hCC);
      chk("rst_first_in_ready", 32'(in_ready), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
